dispatch: RTL



---
 rtl/dispatch_pkg.sv | 30 +++
 rtl/dispatch_preg_ready_table.sv | 48 ++++
 rtl/dispatch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared types for the dual-slot dispatch stage.
// DISP_BYPASS_EN (optional) enables same-cycle completion bypass.
package dispatch_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int PREG_COUNT = 64;
  localparam int RS_DEPTH   = 8;

  localparam int TAG_W  = $clog2(ROB_DEPTH);
  localparam int PREG_W = $clog2(PREG_COUNT);
  localparam int RSC_W  = $clog2(RS_DEPTH) + 1;

  typedef struct packed {
    logic [6:0]        op;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
  } dispatchStruct;

  typedef struct packed {
    logic [6:0]        op;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [TAG_W-1:0]  rob_tag;
    logic              rs1_rdy;
    logic              rs2_rdy;
  } rsEntryStruct;

endpackage

// File: rtl/dispatch_preg_ready_table.sv
// Physical-register ready table: 2 clear, 2 set, 4 read ports.
// Sets win over clears; p0 is pinned ready.
module preg_ready_table
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_en_a,
  input  logic [PREG_W-1:0] clr_a,
  input  logic              clr_en_b,
  input  logic [PREG_W-1:0] clr_b,
  input  logic              set_en_a,
  input  logic [PREG_W-1:0] set_a,
  input  logic              set_en_b,
  input  logic [PREG_W-1:0] set_b,
  input  logic [PREG_W-1:0] raddr_0,
  input  logic [PREG_W-1:0] raddr_1,
  input  logic [PREG_W-1:0] raddr_2,
  input  logic [PREG_W-1:0] raddr_3,
  output logic              rdy_0,
  output logic              rdy_1,
  output logic              rdy_2,
  output logic              rdy_3
);

  logic [PREG_COUNT-1:0] rdy_q;
  logic [PREG_COUNT-1:0] rdy_d;

  always_comb begin
    rdy_d = rdy_q;
    if (clr_en_a) rdy_d[clr_a] = 1'b0;
    if (clr_en_b) rdy_d[clr_b] = 1'b0;
    if (set_en_a) rdy_d[set_a] = 1'b1;
    if (set_en_b) rdy_d[set_b] = 1'b1;
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rdy_q <= '1;
    else       rdy_q <= rdy_d;
  end

  assign rdy_0 = rdy_q[raddr_0];
  assign rdy_1 = rdy_q[raddr_1];
  assign rdy_2 = rdy_q[raddr_2];
  assign rdy_3 = rdy_q[raddr_3];

endmodule

// File: rtl/dispatch.sv
// Dual-slot in-order dispatch: ROB tag allocation, RS write, stall.
// DISP_BYPASS_EN: completions in the dispatch cycle mark sources ready.
module dispatch
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  dispatchStruct     ren_disp_reg_a,
  input  dispatchStruct     ren_disp_reg_b,
  input  logic              ren_disp_valid_a,
  input  logic              ren_disp_valid_b,
  output logic              disp_stall,
  input  logic [RSC_W-1:0]  rs_free_cnt,
  input  logic [1:0]        rob_retire_cnt,
  input  logic              cmp_valid_a,
  input  logic              cmp_valid_b,
  input  logic [PREG_W-1:0] cmp_prd_a,
  input  logic [PREG_W-1:0] cmp_prd_b,
  output logic              disp_rs_valid_a,
  output logic              disp_rs_valid_b,
  output rsEntryStruct      disp_rs_entry_a,
  output rsEntryStruct      disp_rs_entry_b,
  output logic [TAG_W-1:0]  disp_rob_tag_a,
  output logic [TAG_W-1:0]  disp_rob_tag_b
);

  dispatchStruct    pa, pb;
  logic             pa_v, pb_v;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   rob_count;
  logic [TAG_W:0]   rob_free, rs_free, avail;
  logic             go_a, go_b, fwd;
  logic [1:0]       n_disp;
  logic [3:0]       tbl, byp;
  rsEntryStruct     ent_a, ent_b;

  assign rob_free = (TAG_W+1)'(ROB_DEPTH) - rob_count;
  assign rs_free  = (TAG_W+1)'(rs_free_cnt);
  assign avail    = (rob_free < rs_free) ? rob_free : rs_free;

  assign go_a = pa_v && (avail != '0);
  assign go_b = pb_v && (pa_v ? (go_a && avail > (TAG_W+1)'(1))
                              : (avail != '0));
  assign disp_stall = (pa_v && !go_a) || (pb_v && !go_b);
  assign n_disp = {1'b0, go_a} + {1'b0, go_b};

  preg_ready_table u_table (
    .clk      (clk),
    .reset    (reset),
    .clr_en_a (go_a && pa.prd != '0),
    .clr_a    (pa.prd),
    .clr_en_b (go_b && pb.prd != '0),
    .clr_b    (pb.prd),
    .set_en_a (cmp_valid_a),
    .set_a    (cmp_prd_a),
    .set_en_b (cmp_valid_b),
    .set_b    (cmp_prd_b),
    .raddr_0  (pa.prs1),
    .raddr_1  (pa.prs2),
    .raddr_2  (pb.prs1),
    .raddr_3  (pb.prs2),
    .rdy_0    (tbl[0]),
    .rdy_1    (tbl[1]),
    .rdy_2    (tbl[2]),
    .rdy_3    (tbl[3])
  );

`ifdef DISP_BYPASS_EN
  function automatic logic hit(logic [PREG_W-1:0] src);
    return (cmp_valid_a && cmp_prd_a == src) ||
           (cmp_valid_b && cmp_prd_b == src);
  endfunction
`endif

  always_comb begin
    byp = '0;
`ifdef DISP_BYPASS_EN
    byp[0] = hit(pa.prs1);
    byp[1] = hit(pa.prs2);
    byp[2] = hit(pb.prs1);
    byp[3] = hit(pb.prs2);
`endif
  end

  // B cannot be ready on a value its older pair-mate is about to produce
  assign fwd = pa_v && pb_v && (pa.prd != '0);

  always_comb begin
    ent_a = '0;
    ent_b = '0;
    ent_a.op      = pa.op;
    ent_a.prd     = pa.prd;
    ent_a.prs1    = pa.prs1;
    ent_a.prs2    = pa.prs2;
    ent_a.rob_tag = tail;
    ent_a.rs1_rdy = tbl[0] | byp[0];
    ent_a.rs2_rdy = tbl[1] | byp[1];
    ent_b.op      = pb.op;
    ent_b.prd     = pb.prd;
    ent_b.prs1    = pb.prs1;
    ent_b.prs2    = pb.prs2;
    ent_b.rob_tag = pa_v ? tail + TAG_W'(1) : tail;
    ent_b.rs1_rdy = (tbl[2] | byp[2]) & ~(fwd && pb.prs1 == pa.prd);
    ent_b.rs2_rdy = (tbl[3] | byp[3]) & ~(fwd && pb.prs2 == pa.prd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pa              <= '0;
      pb              <= '0;
      pa_v            <= 1'b0;
      pb_v            <= 1'b0;
      tail            <= '0;
      rob_count       <= '0;
      disp_rs_valid_a <= 1'b0;
      disp_rs_valid_b <= 1'b0;
      disp_rs_entry_a <= '0;
      disp_rs_entry_b <= '0;
      disp_rob_tag_a  <= '0;
      disp_rob_tag_b  <= '0;
    end else begin
      disp_rs_valid_a <= go_a;
      disp_rs_valid_b <= go_b;
      disp_rs_entry_a <= ent_a;
      disp_rs_entry_b <= ent_b;
      disp_rob_tag_a  <= ent_a.rob_tag;
      disp_rob_tag_b  <= ent_b.rob_tag;
      tail      <= tail + TAG_W'(n_disp);
      rob_count <= rob_count + (TAG_W+1)'(n_disp)
                 - (TAG_W+1)'(rob_retire_cnt);
      if (!disp_stall) begin
        pa   <= ren_disp_reg_a;
        pa_v <= ren_disp_valid_a;
        pb   <= ren_disp_reg_b;
        pb_v <= ren_disp_valid_b;
      end else if (go_a && !go_b) begin
        pa   <= pb;
        pa_v <= pb_v;
        pb_v <= 1'b0;
      end
    end
  end

  a_retire_legal: assert property (@(posedge clk) disable iff (reset)
    {{(TAG_W-1){1'b0}}, rob_retire_cnt} <= rob_count);

endmodule
